fifo_pack: RTL and testbench
============================

FIFO_PACK -- requirements
Module: fifo_pack

Interface
REQ-001 Parameter DATA_WIDTH, default 8: narrow (write) word width in bits.
REQ-002 Parameter ADDR_WIDTH, default 4: DEPTH = 2**ADDR_WIDTH narrow words of storage; ADDR_WIDTH >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 wr  input  1  push request for w_data.
REQ-006 w_data  input  DATA_WIDTH  narrow word to push.
REQ-007 rd  input  1  pop request for one wide word (two narrow words).
REQ-008 r_data  output  2*DATA_WIDTH  head wide word, first-word-fall-through.
REQ-009 empty  output  1  high when fewer than 2 narrow words are stored.
REQ-010 full  output  1  high when DEPTH narrow words are stored.
REQ-011 count  output  ADDR_WIDTH+1  number of narrow words stored, 0..DEPTH.
REQ-012 err_ovf  output  1  sticky: a write was dropped because the FIFO was full.
REQ-013 err_udf  output  1  sticky: a read was dropped because empty was high.

Function
REQ-014 Storage: DEPTH x DATA_WIDTH register array; write pointer w_addr (ADDR_WIDTH bits) and read pointer r_addr (ADDR_WIDTH bits); both wrap modulo DEPTH.
REQ-015 Accepted write: mem[w_addr] <= w_data; w_addr += 1.
REQ-016 Accepted read: r_addr += 2; count -= 2.
REQ-017 r_addr[0] is always 0.
REQ-018 r_data[DATA_WIDTH-1:0] = mem[r_addr] (older word); r_data[2*DATA_WIDTH-1:DATA_WIDTH] = mem[r_addr+1] (newer word); combinational from state.
REQ-019 r_data is unspecified while empty = 1; the bench checks it only when empty = 0.
REQ-020 Write acceptance: wr & (~full | rd_acc), where rd_acc = rd & ~empty.
REQ-021 Read acceptance: rd_acc = rd & ~empty; a read is never enabled by a same-cycle write.
REQ-022 count update per cycle: +1 on write only, -2 on read only, -1 on both, unchanged otherwise.
REQ-023 empty = (count < 2); full = (count == DEPTH); both derive from registered count.
REQ-024 FWFT latency: the write that makes count = 2 deasserts empty and presents valid r_data in the cycle after that clock edge.
REQ-025 Full with rd & wr: both accepted; count becomes DEPTH-1.
REQ-026 count = 1 with rd & wr: the read is dropped and err_udf sets; the write is accepted and count becomes 2.
REQ-027 count = 0 with rd: no state change except that err_udf sets.
REQ-028 Full with wr & ~rd: the write is dropped, mem and w_addr are unchanged, and err_ovf sets.
REQ-029 err_ovf and err_udf, once set, hold until reset.
REQ-030 The w_addr wrap from DEPTH-1 to 0 and the r_addr wrap from DEPTH-2 to 0 are seamless; data order is preserved across the wrap.

Reset
REQ-031 reset = 0 immediately, without waiting for clk, forces: w_addr = 0, r_addr = 0, count = 0, empty = 1, full = 0, err_ovf = 0, err_udf = 0.
REQ-032 Array contents are not reset.
REQ-033 Reset asserted mid-operation discards all stored data; wr/rd sampled while reset = 0 are ignored.
REQ-034 After reset releases, the first accepted write goes to address 0.

Verification (DATA_WIDTH = 8, ADDR_WIDTH = 4)
REQ-035 Reset, then write 0x11 and 0x22 -> after the second edge: empty = 0, count = 2, r_data = 0x2211; rd for one cycle -> empty = 1, count = 0.
REQ-036 Write 0x00..0x0F (16 writes) -> full = 1, count = 16; a 17th wr with 0xFF -> dropped, err_ovf = 1, then eight reads return 0x0100, 0x0302, ..., 0x0F0E.
REQ-037 Full, then rd & wr with w_data = 0xAA in one cycle -> count = 15, full = 0; 0xAA surfaces in the low byte of the 8th subsequent wide read.
REQ-038 count = 1 (written 0x55), then rd & wr with 0x66 -> err_udf = 1, count = 2, r_data = 0x6655.
REQ-039 Wrap: 24 writes interleaved with reads so that w_addr passes 15 -> 0 twice -> every wide read matches a reference queue; r_addr[0] = 0 throughout.
REQ-040 reset pulsed low between clock edges while count = 9 and err_ovf = 1 -> outputs follow REQ-031 before the next edge; the next write of 0x77 plus 0x88 reads back as 0x8877.

Source files
------------

// File: rtl/fifo_pack_if.sv
// Bus bundle for fifo_pack: narrow-word push side, wide-word FWFT pop side
// and the occupancy / sticky error flags.
interface fifo_pack_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                      wr;
    logic [DATA_WIDTH-1:0]     w_data;
    logic                      rd;
    logic [2*DATA_WIDTH-1:0]   r_data;
    logic                      empty;
    logic                      full;
    logic [ADDR_WIDTH:0]       count;
    logic                      err_ovf;
    logic                      err_udf;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, count, err_ovf, err_udf
    );

    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, count, err_ovf, err_udf
    );
endinterface

// File: rtl/fifo_pack.sv
// Packing FIFO: accepts one narrow word per write, releases two narrow words
// per read as one wide first-word-fall-through word (older word in the low half).
module fifo_pack #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    fifo_pack_if.slave  bus
);
    localparam int                  DEPTH     = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] TWO_CNT   = (ADDR_WIDTH + 1)'(2);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_udf_q, err_udf_d;

    logic                  empty;
    logic                  full;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] r_addr_hi;

    assign empty  = (count_q < TWO_CNT);
    assign full   = (count_q == DEPTH_CNT);
    assign rd_acc = bus.rd & ~empty;
    // A pop in the same cycle frees room, so a full FIFO still takes the write.
    assign wr_acc = bus.wr & (~full | rd_acc);

    // r_addr is always even, so the newer word sits at r_addr with bit 0 set.
    assign r_addr_hi = {r_addr_q[ADDR_WIDTH-1:1], 1'b1};

    always_comb begin
        w_addr_d  = w_addr_q;
        r_addr_d  = r_addr_q;
        count_d   = count_q;
        err_ovf_d = err_ovf_q | (bus.wr & ~wr_acc);
        err_udf_d = err_udf_q | (bus.rd & ~rd_acc);

        if (wr_acc) begin
            w_addr_d = w_addr_q + ADDR_WIDTH'(1);
        end
        if (rd_acc) begin
            r_addr_d = r_addr_q + ADDR_WIDTH'(2);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(2);
            2'b11:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_addr_q  <= '0;
            r_addr_q  <= '0;
            count_q   <= '0;
            err_ovf_q <= 1'b0;
            err_udf_q <= 1'b0;
        end else begin
            w_addr_q  <= w_addr_d;
            r_addr_q  <= r_addr_d;
            count_q   <= count_d;
            err_ovf_q <= err_ovf_d;
            err_udf_q <= err_udf_d;
        end
    end

    // Storage is not reset; the reset term only blocks writes while held in reset.
    always_ff @(posedge clk) begin
        if (reset && wr_acc) begin
            mem_q[w_addr_q] <= bus.w_data;
        end
    end

    assign bus.r_data  = {mem_q[r_addr_hi], mem_q[r_addr_q]};
    assign bus.empty   = empty;
    assign bus.full    = full;
    assign bus.count   = count_q;
    assign bus.err_ovf = err_ovf_q;
    assign bus.err_udf = err_udf_q;
endmodule

// File: tb/tb_fifo_pack.sv
// Self-checking bench for fifo_pack: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_fifo_pack;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    fifo_pack_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fifo_pack #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] q[$];
    logic       m_ovf;
    logic       m_udf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, "_count"}, 32'(bus.count), 32'(q.size()));
        check({tag, "_empty"}, 32'(bus.empty), 32'(q.size() < 2));
        check({tag, "_full"},  32'(bus.full),  32'(q.size() == DEPTH));
        check({tag, "_ovf"},   32'(bus.err_ovf), 32'(m_ovf));
        check({tag, "_udf"},   32'(bus.err_udf), 32'(m_udf));
        check({tag, "_raddr0"}, 32'(dut.r_addr_q[0]), 32'(0));
        if (q.size() >= 2)
            check({tag, "_rdata"}, 32'(bus.r_data), 32'({q[1], q[0]}));
    endtask

    // Called at a negedge; drives inputs, applies the model at the edge, checks at +1.
    task automatic cycle(input string tag, input logic w, input logic [7:0] d, input logic r);
        bit rd_ok, wr_ok;
        bus.wr = w; bus.w_data = d; bus.rd = r;
        @(posedge clk);
        rd_ok = r && (q.size() >= 2);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (r && !rd_ok) m_udf = 1'b1;
        if (w && !wr_ok) m_ovf = 1'b1;
        if (rd_ok) begin
            void'(q.pop_front());
            void'(q.pop_front());
        end
        if (wr_ok) q.push_back(d);
        #1;
        check_model(tag);
        @(negedge clk);
        bus.wr = 1'b0; bus.rd = 1'b0;
    endtask

    initial begin
        q = {};
        m_ovf = 1'b0;
        m_udf = 1'b0;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.w_data = '0;

        // Reset state before any clock edge
        reset = 1'b0;
        #2;
        check_model("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // First pair makes a wide word visible
        cycle("w11", 1'b1, 8'h11, 1'b0);
        cycle("w22", 1'b1, 8'h22, 1'b0);
        check("pair_rdata", 32'(bus.r_data), 32'h2211);
        check("pair_count", 32'(bus.count), 32'd2);
        cycle("rd1", 1'b0, 8'h00, 1'b1);
        check("pair_empty", 32'(bus.empty), 32'd1);

        // Fill, overflow, drain
        for (int i = 0; i < 16; i++) cycle("fill", 1'b1, 8'(i), 1'b0);
        check("fill_full", 32'(bus.full), 32'd1);
        cycle("ovf", 1'b1, 8'hFF, 1'b0);
        check("ovf_flag", 32'(bus.err_ovf), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check("drain_rdata", 32'(bus.r_data), 32'({8'(2*i+1), 8'(2*i)}));
            cycle("drain", 1'b0, 8'h00, 1'b1);
        end

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) cycle("fill2", 1'b1, 8'(8'h20 + i), 1'b0);
        cycle("rdwr_full", 1'b1, 8'hAA, 1'b1);
        check("rdwr_count", 32'(bus.count), 32'd15);
        check("rdwr_full0", 32'(bus.full), 32'd0);
        for (int i = 0; i < 7; i++) cycle("drain2", 1'b0, 8'h00, 1'b1);
        cycle("wbb", 1'b1, 8'hBB, 1'b0);
        check("aa_low", 32'(bus.r_data[7:0]), 32'h00AA);
        cycle("rd8", 1'b0, 8'h00, 1'b1);

        // count = 1 with read and write: read dropped, write taken
        cycle("w55", 1'b1, 8'h55, 1'b0);
        cycle("rdwr_one", 1'b1, 8'h66, 1'b1);
        check("one_udf", 32'(bus.err_udf), 32'd1);
        check("one_count", 32'(bus.count), 32'd2);
        check("one_rdata", 32'(bus.r_data), 32'h6655);
        cycle("rd_one", 1'b0, 8'h00, 1'b1);
        cycle("rd_empty", 1'b0, 8'h00, 1'b1);

        // Random traffic across several pointer wraps
        for (int i = 0; i < 300; i++) begin
            logic w, r;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 30);
            cycle("rand", w, 8'($urandom), r);
        end

        // Bring occupancy to exactly 9 with err_ovf set, then async reset mid-cycle
        while (q.size() >= 2) cycle("prep_rd", 1'b0, 8'h00, 1'b1);
        if (q.size() == 1) begin
            cycle("prep_w", 1'b1, 8'h01, 1'b0);
            cycle("prep_r", 1'b0, 8'h00, 1'b1);
        end
        if (!m_ovf) begin
            for (int i = 0; i < 17; i++) cycle("prep_ovf", 1'b1, 8'(i), 1'b0);
            for (int i = 0; i < 8; i++) cycle("prep_dr", 1'b0, 8'h00, 1'b1);
        end
        for (int i = 0; i < 9; i++) cycle("nine", 1'b1, 8'(8'h90 + i), 1'b0);
        check("nine_count", 32'(bus.count), 32'd9);
        check("nine_ovf", 32'(bus.err_ovf), 32'd1);
        #1;
        reset = 1'b0;
        q = {};
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #1;
        check_model("async_rst");
        #1;
        reset = 1'b1;
        @(negedge clk);
        cycle("w77", 1'b1, 8'h77, 1'b0);
        cycle("w88", 1'b1, 8'h88, 1'b0);
        check("post_rst_rdata", 32'(bus.r_data), 32'h8877);
        check("post_rst_waddr", 32'(dut.w_addr_q), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
